// File: rtl/v850_pkg.sv
// Shared definitions for the V850 front-end: executer circuit selects,
// opcode/subop encodings, decoded-instruction classes and the issue FSM states.
package v850_pkg;

    localparam logic [4:0] CS_SUB = 5'b00000;
    localparam logic [4:0] CS_ADD = 5'b00001;
    localparam logic [4:0] CS_AND = 5'b00010;
    localparam logic [4:0] CS_OR  = 5'b00011;
    localparam logic [4:0] CS_BSH = 5'b00110;
    localparam logic [4:0] CS_BSW = 5'b00111;
    localparam logic [4:0] CS_DIV = 5'b01000;
    localparam logic [4:0] CS_NOP = 5'b11111;

    localparam logic [5:0] OP_OR       = 6'b001000;
    localparam logic [5:0] OP_AND      = 6'b001010;
    localparam logic [5:0] OP_SUB      = 6'b001101;
    localparam logic [5:0] OP_ADD      = 6'b001110;
    localparam logic [5:0] OP_CMP      = 6'b001111;
    localparam logic [5:0] OP_ADD_IMM5 = 6'b010010;
    localparam logic [5:0] OP_CMP_IMM5 = 6'b010011;
    localparam logic [5:0] OP_ADDI     = 6'b110000;
    localparam logic [5:0] OP_ORI      = 6'b110100;
    localparam logic [5:0] OP_ANDI     = 6'b110110;
    localparam logic [5:0] OP_EXT      = 6'b111111;

    localparam logic [10:0] SUBOP_DIV = 11'b01011000000;
    localparam logic [10:0] SUBOP_BSW = 11'b01101000000;
    localparam logic [10:0] SUBOP_BSH = 11'b01101000010;

    localparam logic [3:0] COND_ALWAYS = 4'b0101;
    localparam logic [3:0] COND_Z      = 4'b0010;
    localparam logic [3:0] COND_NZ     = 4'b1010;

    typedef enum logic [1:0] {
        ST_FETCH1,
        ST_FETCH2,
        ST_ISSUE
    } state_e;

    typedef enum logic [3:0] {
        CL_NONE,
        CL_ADD,
        CL_SUB,
        CL_CMP,
        CL_AND,
        CL_OR,
        CL_DIV,
        CL_BSW,
        CL_BSH,
        CL_BCOND
    } inst_class_e;

    // Where operand 1 comes from: the register file or an extended immediate
    typedef enum logic [1:0] {
        EXT_REG,
        EXT_SEXT5,
        EXT_SEXT16,
        EXT_ZEXT16
    } ext_kind_e;

    typedef struct packed {
        logic [4:0]  reg2;
        logic [4:0]  reg1;
        logic [4:0]  reg3;
        logic [15:0] imm16;
        logic [3:0]  cond;
        logic [8:0]  disp9;
    } inst_fields_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational classifier: splits an instruction into its fields and tells
// the decoder what kind of instruction it is, how long it is, how operand 1
// is extended and whether the encoding is unsupported.
module opcode_classifier
    import v850_pkg::*;
(
    input  logic [15:0]  hw0_i,
    input  logic [15:0]  hw1_i,
    output inst_class_e  inst_class_o,
    output logic         is32_o,
    output ext_kind_e    ext_kind_o,
    output logic         illegal_o,
    output inst_fields_t fields_o
);

    logic [5:0]  opcode;
    logic [10:0] subop;

    assign opcode = hw0_i[10:5];
    assign subop  = hw1_i[10:0];
    assign is32_o = (hw0_i[10:9] == 2'b11);

    assign fields_o.reg2  = hw0_i[15:11];
    assign fields_o.reg1  = hw0_i[4:0];
    assign fields_o.reg3  = hw1_i[15:11];
    assign fields_o.imm16 = hw1_i;
    assign fields_o.cond  = hw0_i[3:0];
    assign fields_o.disp9 = {hw0_i[15:11], hw0_i[6:4], 1'b0};

    // Classify the opcode; anything not recognised falls through as illegal
    always_comb begin
        inst_class_o = CL_NONE;
        ext_kind_o   = EXT_REG;
        illegal_o    = 1'b0;
        if (hw0_i[10:7] == 4'b1011) begin
            inst_class_o = CL_BCOND;
            if (hw0_i[3:0] != COND_ALWAYS && hw0_i[3:0] != COND_Z && hw0_i[3:0] != COND_NZ) begin
                illegal_o = 1'b1;
            end
        end else begin
            case (opcode)
                OP_ADD:      inst_class_o = CL_ADD;
                OP_ADD_IMM5: begin inst_class_o = CL_ADD; ext_kind_o = EXT_SEXT5;  end
                OP_ADDI:     begin inst_class_o = CL_ADD; ext_kind_o = EXT_SEXT16; end
                OP_SUB:      inst_class_o = CL_SUB;
                OP_CMP:      inst_class_o = CL_CMP;
                OP_CMP_IMM5: begin inst_class_o = CL_CMP; ext_kind_o = EXT_SEXT5;  end
                OP_AND:      inst_class_o = CL_AND;
                OP_ANDI:     begin inst_class_o = CL_AND; ext_kind_o = EXT_ZEXT16; end
                OP_OR:       inst_class_o = CL_OR;
                OP_ORI:      begin inst_class_o = CL_OR;  ext_kind_o = EXT_ZEXT16; end
                OP_EXT: begin
                    case (subop)
                        SUBOP_DIV: inst_class_o = CL_DIV;
                        SUBOP_BSW: inst_class_o = CL_BSW;
                        SUBOP_BSH: inst_class_o = CL_BSH;
                        default:   illegal_o    = 1'b1;
                    endcase
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/instruction_decoder.sv
// V850 issue stage: assembles 16/32-bit instructions from a halfword stream,
// reads operands and issues one registered micro-op per instruction. Between
// issues the outputs carry the idle code (NOP_SEL, all fields zero).
module instruction_decoder
    import v850_pkg::*;
#(
    parameter logic [4:0] NOP_SEL = CS_NOP
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      inst_i,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic [31:0][31:0] GR_i,
    input  logic [31:0]      PSW_i,
    input  logic [31:0]      PC_i,
    output logic [4:0]       destination_o,
    output logic [31:0]      reg1_o,
    output logic [31:0]      reg2_o,
    output logic [31:0]      reg3_o,
    output logic             increment_bit_o,
    output logic [4:0]       circuit_sel_o,
    output logic             illegal_o
);

    state_e       state_q, state_d;
    logic [15:0]  hw0_q, hw0_d;
    logic [4:0]   circuitSel_q, circuitSel_d;
    logic [4:0]   destination_q, destination_d;
    logic [31:0]  reg1_q, reg1_d;
    logic [31:0]  reg2_q, reg2_d;
    logic [31:0]  reg3_q, reg3_d;
    logic         increment_q, increment_d;
    logic         illegal_q, illegal_d;

    logic [15:0]  curHw0;
    inst_class_e  instClass;
    logic         is32;
    ext_kind_e    extKind;
    logic         isIllegal;
    inst_fields_t fields;

    logic [31:0]  grReg1, grReg2, operand1, dispExt;
    logic         zeroFlag, branchTaken, issueNow;
    logic [4:0]   decSel, decDest;
    logic [31:0]  decReg1, decReg2, decReg3;
    logic         decIllegal;
    logic [30:0]  unusedPsw;

    // In FETCH2 the first halfword comes from the capture register
    assign curHw0 = (state_q == ST_FETCH2) ? hw0_q : inst_i;

    opcode_classifier uClassifier (
        .hw0_i        (curHw0),
        .hw1_i        (inst_i),
        .inst_class_o (instClass),
        .is32_o       (is32),
        .ext_kind_o   (extKind),
        .illegal_o    (isIllegal),
        .fields_o     (fields)
    );

    assign unusedPsw = PSW_i[31:1];
    assign zeroFlag  = PSW_i[0];
    assign grReg1    = (fields.reg1 == 5'd0) ? 32'd0 : GR_i[fields.reg1];
    assign grReg2    = (fields.reg2 == 5'd0) ? 32'd0 : GR_i[fields.reg2];
    assign dispExt   = {{23{fields.disp9[8]}}, fields.disp9};

    // Select operand 1 from the register file or the extended immediate
    always_comb begin
        operand1 = grReg1;
        case (extKind)
            EXT_SEXT5:  operand1 = {{27{fields.reg1[4]}}, fields.reg1};
            EXT_SEXT16: operand1 = {{16{fields.imm16[15]}}, fields.imm16};
            EXT_ZEXT16: operand1 = {16'd0, fields.imm16};
            default:    operand1 = grReg1;
        endcase
    end

    assign branchTaken = (fields.cond == COND_ALWAYS) ||
                         (fields.cond == COND_Z  &&  zeroFlag) ||
                         (fields.cond == COND_NZ && !zeroFlag);

    // Build the micro-op for the instruction currently on the inputs
    always_comb begin
        decSel     = NOP_SEL;
        decDest    = 5'd0;
        decReg1    = 32'd0;
        decReg2    = 32'd0;
        decReg3    = 32'd0;
        decIllegal = 1'b0;
        if (isIllegal) begin
            decIllegal = 1'b1;
        end else begin
            case (instClass)
                CL_ADD: begin
                    // A zero destination would redirect the PC, so it is dropped
                    if (fields.reg2 != 5'd0) begin
                        decSel  = CS_ADD;
                        decDest = fields.reg2;
                        decReg1 = operand1;
                        decReg2 = grReg2;
                    end
                end
                CL_SUB, CL_CMP: begin
                    decSel  = CS_SUB;
                    decDest = (instClass == CL_SUB) ? fields.reg2 : 5'd0;
                    decReg1 = -operand1;
                    decReg2 = grReg2;
                end
                CL_AND, CL_OR: begin
                    decSel  = (instClass == CL_AND) ? CS_AND : CS_OR;
                    decDest = fields.reg2;
                    decReg1 = operand1;
                    decReg2 = grReg2;
                end
                CL_DIV: begin
                    decSel  = CS_DIV;
                    decDest = fields.reg2;
                    decReg1 = grReg1;
                    decReg2 = grReg2;
                    decReg3 = {27'd0, fields.reg3};
                end
                CL_BSW: begin
                    decSel  = CS_BSW;
                    decDest = fields.reg3;
                    decReg2 = {grReg2[7:0], grReg2[15:8], grReg2[23:16], grReg2[31:24]};
                end
                CL_BSH: begin
                    decSel  = CS_BSH;
                    decDest = fields.reg3;
                    decReg2 = {grReg2[23:16], grReg2[31:24], grReg2[7:0], grReg2[15:8]};
                end
                CL_BCOND: begin
                    if (branchTaken) begin
                        decSel  = CS_ADD;
                        decDest = 5'd0;
                        decReg1 = dispExt;
                        decReg2 = PC_i;
                    end
                end
                default: decIllegal = 1'b1;
            endcase
        end
    end

    assign issueNow = inst_valid_i &&
                      ((state_q == ST_FETCH1 && !is32) || state_q == ST_FETCH2);

    // Next-state: fetch halfwords, issue for exactly one cycle, idle otherwise
    always_comb begin
        state_d       = state_q;
        hw0_d         = hw0_q;
        circuitSel_d  = NOP_SEL;
        destination_d = 5'd0;
        reg1_d        = 32'd0;
        reg2_d        = 32'd0;
        reg3_d        = 32'd0;
        increment_d   = 1'b0;
        illegal_d     = 1'b0;
        case (state_q)
            ST_FETCH1: begin
                if (inst_valid_i && is32) begin
                    hw0_d   = inst_i;
                    state_d = ST_FETCH2;
                end
            end
            ST_ISSUE: state_d = ST_FETCH1;
            default:  state_d = state_q;
        endcase
        if (issueNow) begin
            state_d       = ST_ISSUE;
            circuitSel_d  = decSel;
            destination_d = decDest;
            reg1_d        = decReg1;
            reg2_d        = decReg2;
            reg3_d        = decReg3;
            illegal_d     = decIllegal;
        end
    end

    // State and output registers; reset discards any half-assembled instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH1;
            hw0_q         <= 16'd0;
            circuitSel_q  <= NOP_SEL;
            destination_q <= 5'd0;
            reg1_q        <= 32'd0;
            reg2_q        <= 32'd0;
            reg3_q        <= 32'd0;
            increment_q   <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hw0_q         <= hw0_d;
            circuitSel_q  <= circuitSel_d;
            destination_q <= destination_d;
            reg1_q        <= reg1_d;
            reg2_q        <= reg2_d;
            reg3_q        <= reg3_d;
            increment_q   <= increment_d;
            illegal_q     <= illegal_d;
        end
    end

    assign inst_ready_o    = (state_q != ST_ISSUE);
    assign circuit_sel_o   = circuitSel_q;
    assign destination_o   = destination_q;
    assign reg1_o          = reg1_q;
    assign reg2_o          = reg2_q;
    assign reg3_o          = reg3_q;
    assign increment_bit_o = increment_q;
    assign illegal_o       = illegal_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed testbench for instruction_decoder: streams hand-encoded V850
// instructions and compares the issued micro-op against hand-computed values.
module tb_instruction_decoder;

    localparam logic [4:0] NOP = 5'b11111;

    logic              clk;
    logic              rst;
    logic [15:0]       inst_i;
    logic              inst_valid_i;
    logic              inst_ready_o;
    logic [31:0][31:0] gr;
    logic [31:0]       psw;
    logic [31:0]       pc;
    logic [4:0]        destination_o;
    logic [31:0]       reg1_o;
    logic [31:0]       reg2_o;
    logic [31:0]       reg3_o;
    logic              increment_bit_o;
    logic [4:0]        circuit_sel_o;
    logic              illegal_o;

    int testCount = 0;
    int failCount = 0;

    instruction_decoder #(.NOP_SEL(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_i          (inst_i),
        .inst_valid_i    (inst_valid_i),
        .inst_ready_o    (inst_ready_o),
        .GR_i            (gr),
        .PSW_i           (psw),
        .PC_i            (pc),
        .destination_o   (destination_o),
        .reg1_o          (reg1_o),
        .reg2_o          (reg2_o),
        .reg3_o          (reg3_o),
        .increment_bit_o (increment_bit_o),
        .circuit_sel_o   (circuit_sel_o),
        .illegal_o       (illegal_o)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if something wedges beyond every bounded wait
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkIssue(input string tag, input logic [4:0] sel, input logic [4:0] dest,
                              input logic [31:0] r1, input logic [31:0] r2);
        checkOutput({tag, ".sel"},  {27'd0, circuit_sel_o}, {27'd0, sel});
        checkOutput({tag, ".dest"}, {27'd0, destination_o}, {27'd0, dest});
        checkOutput({tag, ".reg1"}, reg1_o, r1);
        checkOutput({tag, ".reg2"}, reg2_o, r2);
    endtask

    // Wait (bounded) for ready, present one halfword for one handshake edge
    task automatic applyStimulus(input logic [15:0] hw);
        int waitCycles;
        waitCycles = 0;
        while (inst_ready_o !== 1'b1 && waitCycles < 20) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        checkOutput("ready_wait", {31'd0, inst_ready_o}, 32'd1);
        inst_i       = hw;
        inst_valid_i = 1'b1;
        @(posedge clk);
        #1;
        inst_valid_i = 1'b0;
        inst_i       = 16'h0000;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        inst_i       = 16'h0000;
        inst_valid_i = 1'b0;
        gr           = '0;
        psw          = 32'd0;
        pc           = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkIssue("reset", NOP, 5'd0, 32'd0, 32'd0);
        checkOutput("reset.reg3", reg3_o, 32'd0);
        checkOutput("reset.inc", {31'd0, increment_bit_o}, 32'd0);
        checkOutput("reset.illegal", {31'd0, illegal_o}, 32'd0);
        checkOutput("reset.ready", {31'd0, inst_ready_o}, 32'd1);

        gr[0] = 32'hDEADBEEF;
        gr[1] = 32'h11223344;
        gr[3] = 32'd5;
        gr[4] = 32'd7;

        // ADD r3,r4
        applyStimulus(16'h21C3);
        checkIssue("add_r", 5'b00001, 5'd4, 32'd5, 32'd7);
        checkOutput("add_r.ready", {31'd0, inst_ready_o}, 32'd0);
        nextCycle();
        checkOutput("add_r.ready_back", {31'd0, inst_ready_o}, 32'd1);
        checkOutput("add_r.sel_idle", {27'd0, circuit_sel_o}, {27'd0, NOP});

        // ADDI 0xFFFF,r2,r6 (first halfword alone issues nothing)
        applyStimulus(16'h3602);
        checkOutput("addi.fetch2_sel", {27'd0, circuit_sel_o}, {27'd0, NOP});
        checkOutput("addi.fetch2_ready", {31'd0, inst_ready_o}, 32'd1);
        applyStimulus(16'hFFFF);
        checkIssue("addi", 5'b00001, 5'd6, 32'hFFFFFFFF, 32'd0);

        // ANDI 0xFFFF zero-extends
        applyStimulus(16'h36C2);
        applyStimulus(16'hFFFF);
        checkIssue("andi", 5'b00010, 5'd6, 32'h0000FFFF, 32'd0);

        // BSW / BSH r1 -> r9
        applyStimulus(16'h0FE0);
        applyStimulus(16'h4B40);
        checkIssue("bsw", 5'b00111, 5'd9, 32'd0, 32'h44332211);
        applyStimulus(16'h0FE0);
        applyStimulus(16'h4B42);
        checkIssue("bsh", 5'b00110, 5'd9, 32'd0, 32'h22114433);

        // DIV r3,r4,r7
        applyStimulus(16'h27E3);
        applyStimulus(16'h3AC0);
        checkIssue("div", 5'b01000, 5'd4, 32'd5, 32'd7);
        checkOutput("div.reg3", reg3_o, 32'd7);

        // SUB r3,r4 and SUB r0,r4 (r0 reads as zero)
        applyStimulus(16'h21A3);
        checkIssue("sub", 5'b00000, 5'd4, 32'hFFFFFFFB, 32'd7);
        applyStimulus(16'h21A0);
        checkIssue("sub_r0", 5'b00000, 5'd4, 32'd0, 32'd7);

        // CMP -3,r4 ; ADD -1,r4 ; OR r1,r4 ; ADD r3,r0 dropped
        applyStimulus(16'h227D);
        checkIssue("cmp_imm5", 5'b00000, 5'd0, 32'd3, 32'd7);
        applyStimulus(16'h225F);
        checkIssue("add_imm5", 5'b00001, 5'd4, 32'hFFFFFFFF, 32'd7);
        applyStimulus(16'h2101);
        checkIssue("or_r", 5'b00011, 5'd4, 32'h11223344, 32'd7);
        applyStimulus(16'h01C3);
        checkIssue("add_r0", NOP, 5'd0, 32'd0, 32'd0);
        checkOutput("add_r0.illegal", {31'd0, illegal_o}, 32'd0);

        // BE +8 taken (Z=1) and not taken (Z=0); BR -4
        psw = 32'd1;
        pc  = 32'h00000100;
        applyStimulus(16'h05C2);
        checkIssue("be_taken", 5'b00001, 5'd0, 32'd8, 32'h00000100);
        psw = 32'd0;
        applyStimulus(16'h05C2);
        checkIssue("be_not_taken", NOP, 5'd0, 32'd0, 32'd0);
        applyStimulus(16'hFDE5);
        checkIssue("br_back", 5'b00001, 5'd0, 32'hFFFFFFFC, 32'h00000100);

        // Unsupported condition code and undefined opcode
        applyStimulus(16'h05C0);
        checkOutput("bcond_bad.illegal", {31'd0, illegal_o}, 32'd1);
        applyStimulus(16'h2000);
        checkIssue("undef", NOP, 5'd0, 32'd0, 32'd0);
        checkOutput("undef.illegal", {31'd0, illegal_o}, 32'd1);
        nextCycle();
        checkOutput("undef.illegal_pulse", {31'd0, illegal_o}, 32'd0);

        // Stall five cycles between the two halves of ADDI 0x10,r2,r6
        applyStimulus(16'h3602);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkOutput("stall.sel", {27'd0, circuit_sel_o}, {27'd0, NOP});
        end
        checkOutput("stall.ready", {31'd0, inst_ready_o}, 32'd1);
        applyStimulus(16'h0010);
        checkIssue("stall_addi", 5'b00001, 5'd6, 32'h00000010, 32'd0);

        // Reset while holding a first halfword; the next 16-bit op must be clean
        applyStimulus(16'h36C2);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("rst_fetch2.ready", {31'd0, inst_ready_o}, 32'd1);
        checkOutput("rst_fetch2.sel", {27'd0, circuit_sel_o}, {27'd0, NOP});
        applyStimulus(16'h21C3);
        checkIssue("after_rst", 5'b00001, 5'd4, 32'd5, 32'd7);

        nextCycle();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Front-end issue stage for the V850 core. Accepts the instruction stream as 16-bit halfwords over a valid/ready handshake and assembles 16- or 32-bit instructions. Reads operands from the executer's register file and PC/PSW, then issues one registered micro-op (circuit select, destination, operands) per instruction to the executer. Drives an idle code whenever nothing is issued.

## Interface
Parameters:
- NOP_SEL, 5'b11111, circuit select meaning "no operation" (decoded by no executer circuit)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_i  in  16  instruction halfword
- inst_valid_i  in  1  halfword present
- inst_ready_o  out  1  decoder can accept a halfword
- GR_i  in  32x32  general registers from executer
- PSW_i  in  32  program status word from executer
- PC_i  in  32  PC of the instruction being decoded
- destination_o  out  5  destination register number (0 = PC on circuit 00001)
- reg1_o  out  32  operand 1
- reg2_o  out  32  operand 2
- reg3_o  out  32  DIV remainder register number, zero-extended
- increment_bit_o  out  1  carry-in
- circuit_sel_o  out  5  executer circuit select
- illegal_o  out  1  one-cycle pulse: unsupported encoding

## Operation
- States: FETCH1, FETCH2, ISSUE. Reset enters FETCH1.
- Length rule: halfword 0 is 32-bit when bits[10:9]==2'b11; otherwise 16-bit.
- Fields:
  - hw0[15:11] = reg2, hw0[4:0] = reg1/imm5, hw0[10:5] = opcode.
  - hw1 = imm16, or hw1[15:11] = reg3 and hw1[10:0] = subop.
- Operand reads: GR_i[0] always reads as zero.
- Sign extension: imm5 and imm16 are sign-extended, except for ANDI/ORI, which zero-extend imm16.
- ALU decodes:
  - ADD r: opcode 001110 → sel 00001, dest=reg2, reg1_o=GR[reg1], reg2_o=GR[reg2], increment=0.
  - ADD imm5: opcode 010010 → as ADD r, with reg1_o=imm5.
  - ADDI: opcode 110000 → as ADD r, with reg1_o=imm16 and dest=reg2.
  - ADD/ADDI with reg2==0: issue NOP_SEL, no illegal pulse. Destination 0 would write PC.
  - SUB: opcode 001101 → sel 00000, reg1_o=−GR[reg1] (two's complement, 32-bit wrap), dest=reg2.
  - CMP r: opcode 001111 → as SUB, dest=0.
  - CMP imm5: opcode 010011 → as CMP r, with reg1_o=−imm5.
  - AND: opcode 001010 → sel 00010. ANDI: opcode 110110 → sel 00010, reg1_o=imm16.
  - OR: opcode 001000 → sel 00011. ORI: opcode 110100 → sel 00011, reg1_o=imm16.
- DIV: opcode 111111 with subop 01011000000 → sel 01000, dest=reg2, reg1_o=GR[reg1], reg2_o=GR[reg2], reg3_o=reg3.
- Byte swaps (opcode 111111; dest=reg3, reg2_o=swapped GR[reg2]):
  - BSW (subop 01101000000) → sel 00111, reg2_o byte-reversed.
  - BSH (subop 01101000010) → sel 00110, bytes swapped within each halfword.
- Bcond: hw0[10:7]==1011.
  - disp = sign-extended {hw0[15:11], hw0[6:4], 1'b0}.
  - Supported conditions: 0101 always; 0010 Z=1; 1010 Z=0.
  - Taken → sel 00001, dest=0, reg2_o=PC_i, reg1_o=disp.
  - Not taken → NOP_SEL.
  - Other condition codes → illegal.
- Any other encoding → NOP_SEL issued, illegal_o pulsed.

## Timing
- inst_ready_o = 1 in FETCH1 and FETCH2, 0 in ISSUE.
- FETCH1 handshake:
  - 16-bit instruction: decode and register all outputs on the same edge → ISSUE.
  - 32-bit instruction: capture hw0 → FETCH2.
- FETCH2 handshake: decode {hw0, inst_i} with GR_i/PSW_i sampled at that edge → ISSUE.
- ISSUE lasts exactly 1 cycle, then → FETCH1. The executer commits at the edge ending ISSUE; circuit_sel_o returns to NOP_SEL on that same edge.
- Throughput: 16-bit instruction every 2 cycles, 32-bit every 3. The next operand read sees the prior write-back; no forwarding is needed.
- circuit_sel_o is not NOP_SEL only in ISSUE. illegal_o is high only in ISSUE of an illegal instruction.
- inst_valid_i low holds the current state indefinitely. Outputs hold NOP_SEL.
- Reset values:
  - circuit_sel_o=NOP_SEL.
  - destination_o, reg1_o, reg2_o, reg3_o, increment_bit_o, illegal_o = 0.
  - inst_ready_o=1 in the first cycle after reset.
- rst in FETCH2 or ISSUE: captured hw0 discarded, the issue is cancelled (sel forced to NOP_SEL on that edge), state → FETCH1.

## Structure
- Shared package v850_pkg holds:
  - circuit-select constants (CS_ADD=00001, CS_SUB=00000, CS_AND, CS_OR, CS_BSH, CS_BSW, CS_DIV, CS_NOP);
  - opcode and subop constants;
  - the state enum.
- Natural sub-module: opcode_classifier. It is combinational: takes hw0/hw1 and outputs instruction class, length flag, immediate-extension kind, and illegal flag.
- FSM, operand read, negation, swaps and branch evaluation stay in instruction_decoder.

## Test plan
- GR[3]=5, GR[4]=7. Stream ADD r3,r4 (0x21C3) → ISSUE: sel 00001, dest 4, reg1_o 5, reg2_o 7. Ready low 1 cycle.
- ADDI 0xFFFF,r2,r6 (hw0 0x3602, hw1 0xFFFF) → reg1_o 0xFFFFFFFF, dest 6. ANDI with the same imm → reg1_o 0x0000FFFF.
- GR[1]=0x11223344. BSW r1 → r9 → sel 00111, dest 9, reg2_o 0x44332211. BSH → reg2_o 0x22114433.
- PSW_i Z=1, PC_i 0x100, BE disp +8 → sel 00001, dest 0, reg2_o 0x100, reg1_o 8. With Z=0 → NOP_SEL.
- Undefined opcode → NOP_SEL plus a 1-cycle illegal_o. inst_valid_i low for 5 cycles → outputs stay NOP_SEL, state unchanged.
- Assert rst during FETCH2 → next cycle FETCH1. A following 16-bit instruction decodes correctly with no stale hw0.
